// File: rtl/muntjac_fetch_redirect_arbiter_pkg.sv
// Shared frontend types: fetch redirect reasons and backend system-redirect kinds.
// System reasons are the 2-bit kind with 2'b11 appended, so the mapping is a plain concatenation.
package cpu_common;

    typedef enum logic [3:0] {
        IF_PREFETCH     = 4'b0000,
        IF_MISPREDICT   = 4'b0001,
        IF_PREDICT      = 4'b0010,
        IF_PROT_CHANGED = 4'b0011,
        IF_SATP_CHANGED = 4'b0111,
        IF_FENCE_I      = 4'b1011,
        IF_SFENCE_VMA   = 4'b1111
    } if_reason_t;

    typedef enum logic [1:0] {
        SYS_PROT,
        SYS_SATP,
        SYS_FENCE_I,
        SYS_SFENCE_VMA
    } sys_redirect_e;

    function automatic if_reason_t sys_reason(sys_redirect_e kind);
        return if_reason_t'({kind, 2'b11});
    endfunction

endpackage

// File: rtl/muntjac_fetch_redirect_arbiter_if.sv
// Redirect sources (backend system, mispredict, predictor) plus the held request to fetch.
// master = arbiter side, slave = backend/predictor/fetch side.
interface muntjac_fetch_redirect_arbiter_if #(
    parameter int AddrWidth  = 64,
    parameter int EpochWidth = 2
);
    import cpu_common::*;

    logic                  sys_valid;
    sys_redirect_e         sys_kind;
    logic [AddrWidth-1:0]  sys_pc;
    logic                  misp_valid;
    logic [AddrWidth-1:0]  misp_pc;
    logic                  pred_valid;
    logic [AddrWidth-1:0]  pred_pc;

    logic                  redirect_valid;
    logic                  redirect_ready;
    logic [AddrWidth-1:0]  redirect_pc;
    if_reason_t            redirect_reason;
    logic                  flush;
    logic [EpochWidth-1:0] epoch;

    modport master (
        input  sys_valid, sys_kind, sys_pc,
        input  misp_valid, misp_pc,
        input  pred_valid, pred_pc,
        input  redirect_ready,
        output redirect_valid, redirect_pc, redirect_reason, flush, epoch
    );

    modport slave (
        output sys_valid, sys_kind, sys_pc,
        output misp_valid, misp_pc,
        output pred_valid, pred_pc,
        output redirect_ready,
        input  redirect_valid, redirect_pc, redirect_reason, flush, epoch
    );

endinterface

// File: rtl/muntjac_fetch_redirect_arbiter.sv
// Merges system, mispredict and predictor redirects into one held request to fetch, with epoch/flush.
// Latency 1 cycle from capture to outputs; request held until fetch accepts (valid & ready).
module muntjac_fetch_redirect_arbiter
    import cpu_common::*;
#(
    parameter int AddrWidth  = 64,
    parameter int EpochWidth = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    muntjac_fetch_redirect_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRED,
        ST_BACK
    } state_e;

    state_e                state_q, state_d;
    state_e                base_state;
    logic [AddrWidth-1:0]  pc_q, pc_d;
    if_reason_t            reason_q, reason_d;
    logic [EpochWidth-1:0] epoch_q, epoch_d;
    logic                  flush_q, flush_d;
    logic                  handshake;

    always_comb begin
        handshake  = (state_q != ST_IDLE) && bus.redirect_ready;
        // A completing handshake frees the slot, so a same-edge request reloads it without a bubble.
        base_state = handshake ? ST_IDLE : state_q;
        state_d    = base_state;
        pc_d       = pc_q;
        reason_d   = reason_q;
        epoch_d    = epoch_q;
        flush_d    = 1'b0;

        if (bus.sys_valid) begin
            state_d  = ST_BACK;
            pc_d     = bus.sys_pc;
            reason_d = sys_reason(bus.sys_kind);
            epoch_d  = epoch_q + EpochWidth'(1);
            flush_d  = 1'b1;
        end else if (bus.misp_valid) begin
            state_d  = ST_BACK;
            pc_d     = bus.misp_pc;
            reason_d = IF_MISPREDICT;
            epoch_d  = epoch_q + EpochWidth'(1);
            flush_d  = 1'b1;
        end else if (bus.pred_valid && (base_state != ST_BACK)) begin
            // A pending backend redirect always outranks the predictor.
            state_d  = ST_PRED;
            pc_d     = bus.pred_pc;
            reason_d = IF_PREDICT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            reason_q <= IF_PREFETCH;
            epoch_q  <= '0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            reason_q <= reason_d;
            epoch_q  <= epoch_d;
            flush_q  <= flush_d;
        end
    end

    assign bus.redirect_valid  = (state_q != ST_IDLE);
    assign bus.redirect_pc     = pc_q;
    assign bus.redirect_reason = reason_q;
    assign bus.flush           = flush_q;
    assign bus.epoch           = epoch_q;

endmodule

// File: tb/tb_muntjac_fetch_redirect_arbiter.sv
// Directed scenarios plus randomized traffic, checked against a pending-request model each cycle.
module tb_muntjac_fetch_redirect_arbiter;
    import cpu_common::*;

    localparam int AW = 64;
    localparam int EW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muntjac_fetch_redirect_arbiter_if #(.AddrWidth(AW), .EpochWidth(EW)) bus ();

    muntjac_fetch_redirect_arbiter #(.AddrWidth(AW), .EpochWidth(EW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one pending slot, whether it holds a backend redirect, and the epoch count.
    bit          m_vld;
    bit          m_back;
    logic [63:0] m_pc;
    logic [3:0]  m_rsn;
    int          m_epoch;
    bit          m_flush;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(bit sv, logic [1:0] sk, logic [63:0] spc, bit mv, logic [63:0] mpc,
                         bit pv, logic [63:0] ppc, bit rdy);
        bus.sys_valid      = sv;
        bus.sys_kind       = sys_redirect_e'(sk);
        bus.sys_pc         = spc;
        bus.misp_valid     = mv;
        bus.misp_pc        = mpc;
        bus.pred_valid     = pv;
        bus.pred_pc        = ppc;
        bus.redirect_ready = rdy;
    endtask

    task automatic idle_in(bit rdy);
        drive(1'b0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, rdy);
    endtask

    task automatic model_step();
        if (rst) begin
            m_vld = 0; m_back = 0; m_pc = 0; m_rsn = 4'b0000; m_epoch = 0; m_flush = 0;
            return;
        end
        if (m_vld && bus.redirect_ready) begin
            m_vld  = 0;
            m_back = 0;
        end
        m_flush = 0;
        if (bus.sys_valid) begin
            m_vld = 1; m_back = 1; m_pc = bus.sys_pc; m_rsn = {bus.sys_kind, 2'b11};
            m_epoch = (m_epoch + 1) % (1 << EW); m_flush = 1;
        end else if (bus.misp_valid) begin
            m_vld = 1; m_back = 1; m_pc = bus.misp_pc; m_rsn = 4'b0001;
            m_epoch = (m_epoch + 1) % (1 << EW); m_flush = 1;
        end else if (bus.pred_valid && !m_back) begin
            m_vld = 1; m_pc = bus.pred_pc; m_rsn = 4'b0010;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("valid", 64'(bus.redirect_valid), 64'(m_vld));
        chk("flush", 64'(bus.flush), 64'(m_flush));
        chk("epoch", 64'(bus.epoch), 64'(m_epoch));
        if (m_vld || rst) begin
            chk("pc", bus.redirect_pc, m_pc);
            chk("reason", 64'(bus.redirect_reason), 64'(m_rsn));
        end
    endtask

    initial begin
        int e0;
        rst = 1'b1;
        idle_in(1'b0);
        step();
        step();
        rst = 1'b0;

        // Reset while a request is pending drops it.
        drive(0, 2'b00, 0, 1, 64'h500, 0, 0, 0);
        step();
        idle_in(1'b0);
        step();
        rst = 1'b1;
        step();
        step();
        chk("rst_valid", 64'(bus.redirect_valid), 64'h0);
        chk("rst_pc", bus.redirect_pc, 64'h0);
        chk("rst_reason", 64'(bus.redirect_reason), 64'h0);
        chk("rst_epoch", 64'(bus.epoch), 64'h0);
        chk("rst_flush", 64'(bus.flush), 64'h0);
        rst = 1'b0;

        // Predictor redirect, accepted immediately.
        drive(0, 2'b00, 0, 0, 0, 1, 64'h1000, 1);
        step();
        chk("pred_valid", 64'(bus.redirect_valid), 64'h1);
        chk("pred_reason", 64'(bus.redirect_reason), 64'h2);
        chk("pred_pc", bus.redirect_pc, 64'h1000);
        chk("pred_flush", 64'(bus.flush), 64'h0);
        idle_in(1'b1);
        step();
        chk("pred_done", 64'(bus.redirect_valid), 64'h0);

        // Mispredict overrides a stalled predictor redirect; later predictor ignored.
        drive(0, 2'b00, 0, 0, 0, 1, 64'h1000, 0);
        step();
        drive(0, 2'b00, 0, 1, 64'h2000, 0, 0, 0);
        step();
        chk("misp_valid", 64'(bus.redirect_valid), 64'h1);
        chk("misp_pc", bus.redirect_pc, 64'h2000);
        chk("misp_reason", 64'(bus.redirect_reason), 64'h1);
        chk("misp_flush", 64'(bus.flush), 64'h1);
        chk("misp_epoch", 64'(bus.epoch), 64'h1);
        drive(0, 2'b00, 0, 0, 0, 1, 64'h3000, 0);
        step();
        chk("misp_flush_end", 64'(bus.flush), 64'h0);
        chk("misp_pc_kept", bus.redirect_pc, 64'h2000);
        chk("misp_reason_kept", 64'(bus.redirect_reason), 64'h1);
        idle_in(1'b1);
        step();
        chk("misp_done", 64'(bus.redirect_valid), 64'h0);

        // All three sources in one cycle: system wins, epoch advances once.
        e0 = m_epoch;
        drive(1, 2'b11, 64'h80, 1, 64'h90, 1, 64'hA0, 0);
        step();
        chk("prio_pc", bus.redirect_pc, 64'h80);
        chk("prio_reason", 64'(bus.redirect_reason), 64'hF);
        chk("prio_epoch", 64'(bus.epoch), 64'((e0 + 1) % (1 << EW)));
        idle_in(1'b1);
        step();

        // New mispredict on the handshake edge: no bubble.
        drive(0, 2'b00, 0, 0, 0, 1, 64'h700, 0);
        step();
        drive(0, 2'b00, 0, 1, 64'h400, 0, 0, 1);
        step();
        chk("nobubble_valid", 64'(bus.redirect_valid), 64'h1);
        chk("nobubble_pc", bus.redirect_pc, 64'h400);
        chk("nobubble_reason", 64'(bus.redirect_reason), 64'h1);

        // Predictor on backend handshake edge is captured.
        drive(0, 2'b00, 0, 0, 0, 1, 64'h600, 1);
        step();
        chk("pred_after_back_valid", 64'(bus.redirect_valid), 64'h1);
        chk("pred_after_back_pc", bus.redirect_pc, 64'h600);
        chk("pred_after_back_reason", 64'(bus.redirect_reason), 64'h2);
        idle_in(1'b1);
        step();

        // Bring epoch to 3, then four back-to-back mispredicts wrap it.
        for (int k = 0; k < 4 && m_epoch != 3; k++) begin
            drive(0, 2'b00, 0, 1, 64'h10, 0, 0, 1);
            step();
        end
        idle_in(1'b1);
        step();
        chk("b2b_start_epoch", 64'(bus.epoch), 64'h3);
        for (int i = 0; i < 4; i++) begin
            drive(0, 2'b00, 0, 1, 64'h100 + 64'(i), 0, 0, 0);
            step();
            chk("b2b_epoch", 64'(bus.epoch), 64'(i));
            chk("b2b_flush", 64'(bus.flush), 64'h1);
        end
        idle_in(1'b1);
        step();
        chk("b2b_flush_end", 64'(bus.flush), 64'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(99, 0) < 1);
            drive($urandom_range(99, 0) < 10, 2'($urandom_range(3, 0)), {$urandom, $urandom},
                  $urandom_range(99, 0) < 15, {$urandom, $urandom},
                  $urandom_range(99, 0) < 30, {$urandom, $urandom},
                  $urandom_range(99, 0) < 50);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
